fpnew_opgroup_result_arbiter: RTL and testbench

- Successor to the per-opgroup output arbitration stage: collects results from NumIn format slices and emits one result stream to the FPU top.
- Adds per-slice result buffering, a configurable arbitration mode (round-robin or issue-order), flush support and occupancy-based busy reporting.
- Sits between the format slices of an opgroup block and the top-level opgroup arbiter.
- Issue-order mode retires results in dispatch order even when slices have unequal pipeline depths.

---
 rtl/fpnew_opgroup_result_arbiter_pkg.sv | 13 +
 rtl/fpnew_result_fifo.sv | 60 ++++++
 rtl/fpnew_opgroup_result_arbiter.sv | 151 +++++++++++++++
 tb/tb_fpnew_opgroup_result_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpnew_opgroup_result_arbiter_pkg.sv
// Shared types and helpers for the opgroup result arbiter and its result FIFOs.
package fpnew_opgroup_result_arbiter_pkg;

    typedef enum logic {
        ARB_RR      = 1'b0,
        ARB_INORDER = 1'b1
    } arb_mode_e;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fpnew_result_fifo.sv
// Synchronous FIFO with full/empty/usage and flush; depth need not be a power of two.
module fpnew_result_fifo
    import fpnew_opgroup_result_arbiter_pkg::*;
#(
    parameter int unsigned Depth  = 2,
    parameter int unsigned Width  = 38,
    parameter int unsigned UsageW = $clog2(Depth + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              push_i,
    input  logic [Width-1:0]  data_i,
    input  logic              pop_i,
    output logic [Width-1:0]  data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [UsageW-1:0] usage_o
);
    localparam int unsigned PtrW = clog2_min1(Depth);

    logic [Width-1:0]  r_mem [Depth];
    logic [PtrW-1:0]   r_wptr;
    logic [PtrW-1:0]   r_rptr;
    logic [UsageW-1:0] r_usage;
    logic              w_push;
    logic              w_pop;

    function automatic logic [PtrW-1:0] wrap_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full_o  = (r_usage == UsageW'(Depth));
    assign empty_o = (r_usage == '0);
    assign usage_o = r_usage;
    assign data_o  = r_mem[r_rptr];
    assign w_push  = push_i & ~full_o;
    assign w_pop   = pop_i & ~empty_o;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_usage <= '0;
        end else begin
            if (w_push) r_wptr <= wrap_inc(r_wptr);
            if (w_pop)  r_rptr <= wrap_inc(r_rptr);
            case ({w_push, w_pop})
                2'b10:   r_usage <= r_usage + UsageW'(1);
                2'b01:   r_usage <= r_usage - UsageW'(1);
                default: r_usage <= r_usage;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wptr] <= data_i;
    end

endmodule

// File: rtl/fpnew_opgroup_result_arbiter.sv
// Buffers per-slice results and merges them into one stream, either round-robin
// or in dispatch order, with flush and occupancy-based busy.
module fpnew_opgroup_result_arbiter
    import fpnew_opgroup_result_arbiter_pkg::*;
#(
    parameter int unsigned NumIn      = 5,
    parameter int unsigned DataWidth  = 38,
    parameter int unsigned BufDepth   = 2,
    parameter int unsigned InOrder    = 0,
    parameter int unsigned OrderDepth = 8,
    parameter int unsigned IdxW       = clog2_min1(NumIn)
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            flush_i,
    input  logic                            issue_valid_i,
    input  logic [IdxW-1:0]                 issue_idx_i,
    output logic                            issue_ready_o,
    input  logic [NumIn-1:0]                in_valid_i,
    output logic [NumIn-1:0]                in_ready_o,
    input  logic [NumIn-1:0][DataWidth-1:0] in_data_i,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic [DataWidth-1:0]            out_data_o,
    output logic [IdxW-1:0]                 out_idx_o,
    output logic                            busy_o
);
    localparam arb_mode_e   Mode    = (InOrder != 0) ? ARB_INORDER : ARB_RR;
    localparam int unsigned BufUseW = $clog2(BufDepth + 1);
    localparam int unsigned OrdUseW = $clog2(OrderDepth + 1);

    logic [NumIn-1:0]                w_full;
    logic [NumIn-1:0]                w_empty;
    logic [NumIn-1:0]                w_occ;
    logic [NumIn-1:0]                w_pop;
    logic [NumIn-1:0][DataWidth-1:0] w_head;
    logic [NumIn-1:0][BufUseW-1:0]   w_usage;
    logic [(2**IdxW)-1:0]            w_empty_ext;

    logic                            w_ord_push;
    logic                            w_ord_pop;
    logic                            w_ord_full;
    logic                            w_ord_empty;
    logic [IdxW-1:0]                 w_ord_head;
    logic [OrdUseW-1:0]              w_ord_usage;

    logic [IdxW-1:0]                 r_rr_ptr;
    logic                            r_hold;
    logic [IdxW-1:0]                 r_hold_idx;
    logic [IdxW-1:0]                 w_win;
    logic [IdxW:0]                   w_cand;
    logic                            w_found;
    logic                            w_hs;

    for (genvar g = 0; g < NumIn; g++) begin : g_buf
        fpnew_result_fifo #(
            .Depth (BufDepth),
            .Width (DataWidth)
        ) u_buf (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .flush_i (flush_i),
            .push_i  (in_valid_i[g]),
            .data_i  (in_data_i[g]),
            .pop_i   (w_pop[g]),
            .data_o  (w_head[g]),
            .full_o  (w_full[g]),
            .empty_o (w_empty[g]),
            .usage_o (w_usage[g])
        );
        assign w_occ[g] = (w_usage[g] != '0);
    end

    fpnew_result_fifo #(
        .Depth (OrderDepth),
        .Width (IdxW)
    ) u_order (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .push_i  (w_ord_push),
        .data_i  (issue_idx_i),
        .pop_i   (w_ord_pop),
        .data_o  (w_ord_head),
        .full_o  (w_ord_full),
        .empty_o (w_ord_empty),
        .usage_o (w_ord_usage)
    );

    // Indices beyond NumIn read as empty so a stray order entry can never select garbage.
    always_comb begin
        w_empty_ext              = '1;
        w_empty_ext[NumIn-1:0]   = w_empty;
    end

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_cand  = '0;
        if (Mode == ARB_INORDER) begin
            w_win   = w_ord_head;
            w_found = ~w_ord_empty & ~w_empty_ext[w_ord_head];
        end else if (r_hold) begin
            w_win   = r_hold_idx;
            w_found = 1'b1;
        end else begin
            for (int unsigned k = 0; k < NumIn; k++) begin
                w_cand = {1'b0, r_rr_ptr} + (IdxW + 1)'(k);
                if (w_cand >= (IdxW + 1)'(NumIn)) w_cand = w_cand - (IdxW + 1)'(NumIn);
                if (!w_found && !w_empty_ext[w_cand[IdxW-1:0]]) begin
                    w_found = 1'b1;
                    w_win   = w_cand[IdxW-1:0];
                end
            end
        end
    end

    assign w_hs = w_found & out_ready_i;

    always_comb begin
        w_pop = '0;
        if (w_hs) w_pop[w_win] = 1'b1;
    end

    assign w_ord_push    = (Mode == ARB_INORDER) & issue_valid_i;
    assign w_ord_pop     = (Mode == ARB_INORDER) & w_hs;
    assign issue_ready_o = (Mode == ARB_INORDER) ? ~w_ord_full : 1'b1;
    assign in_ready_o    = ~w_full;
    assign out_valid_o   = w_found;
    assign out_idx_o     = w_found ? w_win : '0;
    assign out_data_o    = w_found ? w_head[w_win] : '0;
    assign busy_o        = (|w_occ) | (w_ord_usage != '0);

    // A presented but unaccepted winner is pinned so out_* stay stable until taken.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_rr_ptr   <= '0;
            r_hold     <= 1'b0;
            r_hold_idx <= '0;
        end else if (Mode == ARB_RR) begin
            if (w_hs) begin
                r_rr_ptr <= (w_win == IdxW'(NumIn - 1)) ? '0 : w_win + IdxW'(1);
                r_hold   <= 1'b0;
            end else if (w_found) begin
                r_hold     <= 1'b1;
                r_hold_idx <= w_win;
            end
        end
    end

endmodule

// File: tb/tb_fpnew_opgroup_result_arbiter.sv
// Checks a round-robin and an issue-order arbiter against a queue-based model,
// plus directed scenarios with literal expectations.
module tb_fpnew_opgroup_result_arbiter;
    localparam int N  = 5;
    localparam int DW = 38;
    localparam int BD = 2;
    localparam int OD = 8;
    localparam int IW = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 flush;
    logic                 issue_valid;
    logic [IW-1:0]        issue_idx;
    logic [N-1:0]         in_valid;
    logic [N-1:0][DW-1:0] in_data;
    logic                 out_ready;

    logic                 issue_ready [2];
    logic                 out_valid   [2];
    logic                 busy        [2];
    logic [N-1:0]         in_ready    [2];
    logic [DW-1:0]        out_data    [2];
    logic [IW-1:0]        out_idx     [2];

    always #5 clk = ~clk;

    fpnew_opgroup_result_arbiter #(
        .NumIn(N), .DataWidth(DW), .BufDepth(BD), .InOrder(0), .OrderDepth(OD)
    ) dut_rr (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .issue_valid_i(issue_valid), .issue_idx_i(issue_idx), .issue_ready_o(issue_ready[0]),
        .in_valid_i(in_valid), .in_ready_o(in_ready[0]), .in_data_i(in_data),
        .out_valid_o(out_valid[0]), .out_ready_i(out_ready), .out_data_o(out_data[0]),
        .out_idx_o(out_idx[0]), .busy_o(busy[0])
    );

    fpnew_opgroup_result_arbiter #(
        .NumIn(N), .DataWidth(DW), .BufDepth(BD), .InOrder(1), .OrderDepth(OD)
    ) dut_io (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .issue_valid_i(issue_valid), .issue_idx_i(issue_idx), .issue_ready_o(issue_ready[1]),
        .in_valid_i(in_valid), .in_ready_o(in_ready[1]), .in_data_i(in_data),
        .out_valid_o(out_valid[1]), .out_ready_i(out_ready), .out_data_o(out_data[1]),
        .out_idx_o(out_idx[1]), .busy_o(busy[1])
    );

    // Reference model: m=0 round-robin, m=1 issue-order.
    logic [DW-1:0] mq [2][N][$];
    int            oq [$];
    int            rr_ptr   [2];
    bit            hold     [2];
    int            hold_idx [2];
    bit            e_valid  [2];
    int            e_idx    [2];
    logic [DW-1:0] e_data   [2];
    bit            live = 1'b0;
    int            total = 0;
    int            bad = 0;

    function automatic void model_clear();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < N; i++) mq[m][i].delete();
            rr_ptr[m] = 0;
            hold[m]   = 1'b0;
        end
        oq.delete();
    endfunction

    function automatic void predict(int m);
        e_valid[m] = 1'b0;
        e_idx[m]   = 0;
        e_data[m]  = '0;
        if (m == 0) begin
            if (hold[0]) begin
                e_valid[0] = 1'b1;
                e_idx[0]   = hold_idx[0];
            end else begin
                for (int k = 0; k < N; k++) begin
                    int s;
                    s = (rr_ptr[0] + k) % N;
                    if (!e_valid[0] && mq[0][s].size() > 0) begin
                        e_valid[0] = 1'b1;
                        e_idx[0]   = s;
                    end
                end
            end
        end else if (oq.size() > 0) begin
            if (mq[1][oq[0]].size() > 0) begin
                e_valid[1] = 1'b1;
                e_idx[1]   = oq[0];
            end
        end
        if (e_valid[m]) e_data[m] = mq[m][e_idx[m]][0];
    endfunction

    function automatic void model_step(int m);
        bit [N-1:0] rdy;
        bit         iok;
        predict(m);
        for (int i = 0; i < N; i++) rdy[i] = (mq[m][i].size() < BD);
        iok = (m == 1) && issue_valid && (oq.size() < OD);
        if (e_valid[m] && out_ready) begin
            void'(mq[m][e_idx[m]].pop_front());
            if (m == 1) void'(oq.pop_front());
            else rr_ptr[0] = (e_idx[0] + 1) % N;
            hold[m] = 1'b0;
        end else if (e_valid[m] && m == 0) begin
            hold[0]     = 1'b1;
            hold_idx[0] = e_idx[0];
        end
        for (int i = 0; i < N; i++)
            if (in_valid[i] && rdy[i]) mq[m][i].push_back(in_data[i]);
        if (iok) oq.push_back(int'(issue_idx));
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            model_clear();
            live = 1'b1;
        end else if (live) begin
            if (flush) model_clear();
            else for (int m = 0; m < 2; m++) model_step(m);
        end
    end

    always @(negedge clk) begin
        if (live) begin
            for (int m = 0; m < 2; m++) begin
                bit [N-1:0] x_rdy;
                bit         x_busy;
                bit         x_iss;
                predict(m);
                x_busy = (m == 1) && (oq.size() > 0);
                for (int i = 0; i < N; i++) begin
                    x_rdy[i] = (mq[m][i].size() < BD);
                    if (mq[m][i].size() > 0) x_busy = 1'b1;
                end
                x_iss = (m == 0) ? 1'b1 : (oq.size() < OD);
                total++;
                if (out_valid[m] !== e_valid[m] || out_idx[m] !== IW'(e_idx[m]) ||
                    out_data[m] !== e_data[m] || busy[m] !== x_busy ||
                    in_ready[m] !== x_rdy || issue_ready[m] !== x_iss) begin
                    bad++;
                    $display("FAIL cycle_m%0d @%0t got v=%0b i=%0d d=%h b=%0b r=%b ir=%0b want v=%0b i=%0d d=%h b=%0b r=%b ir=%0b",
                             m, $time, out_valid[m], out_idx[m], out_data[m], busy[m], in_ready[m], issue_ready[m],
                             e_valid[m], e_idx[m], e_data[m], x_busy, x_rdy, x_iss);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @%0t got %h want %h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired @%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; issue_valid = 1'b0; issue_idx = '0;
        in_valid = '0; in_data = '0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            chk("rst_valid", 64'(out_valid[m]), 64'd0);
            chk("rst_busy", 64'(busy[m]), 64'd0);
            chk("rst_in_ready", 64'(in_ready[m]), 64'h1f);
            chk("rst_issue_ready", 64'(issue_ready[m]), 64'd1);
            chk("rst_data", 64'(out_data[m]), 64'd0);
            chk("rst_idx", 64'(out_idx[m]), 64'd0);
        end

        // Round-robin fairness
        tick();
        out_ready = 1'b1;
        in_valid = 5'b10101; in_data[0] = 'hA; in_data[2] = 'hB; in_data[4] = 'hC;
        tick();
        in_valid = '0;
        @(negedge clk); chk("rr_a_idx", 64'(out_idx[0]), 64'd0); chk("rr_a_data", 64'(out_data[0]), 64'hA);
        @(negedge clk); chk("rr_b_idx", 64'(out_idx[0]), 64'd2); chk("rr_b_data", 64'(out_data[0]), 64'hB);
        @(negedge clk); chk("rr_c_idx", 64'(out_idx[0]), 64'd4); chk("rr_c_data", 64'(out_data[0]), 64'hC);
        tick();
        in_valid = 5'b01010; in_data[1] = 'h11; in_data[3] = 'h13;
        tick();
        in_valid = '0;
        @(negedge clk); chk("rr_wrap_idx", 64'(out_idx[0]), 64'd1); chk("rr_wrap_data", 64'(out_data[0]), 64'h11);
        @(negedge clk); chk("rr_next_idx", 64'(out_idx[0]), 64'd3);
        tick();
        do_flush();

        // Backpressure stability
        out_ready = 1'b0;
        in_valid = 5'b01010;
        for (int c = 0; c < 5; c++) begin
            in_data[1] = DW'(32'h100 + c);
            in_data[3] = DW'(32'h300 + c);
            tick();
            @(negedge clk);
            chk("bp_idx", 64'(out_idx[0]), 64'd1);
            chk("bp_data", 64'(out_data[0]), 64'h100);
            if (c >= 1) chk("bp_full", 64'(in_ready[0][1]), 64'd0);
        end
        in_valid = '0;
        tick();
        do_flush();

        // Issue order
        out_ready = 1'b1;
        issue_valid = 1'b1; issue_idx = 3'd3;
        tick();
        issue_idx = 3'd0;
        tick();
        issue_valid = 1'b0;
        in_valid = 5'b00001; in_data[0] = 'h50;
        tick();
        in_valid = '0;
        @(negedge clk); chk("io_wait1", 64'(out_valid[1]), 64'd0);
        tick();
        @(negedge clk); chk("io_wait2", 64'(out_valid[1]), 64'd0);
        in_valid = 5'b01000; in_data[3] = 'h53;
        tick();
        in_valid = '0;
        @(negedge clk); chk("io_first_idx", 64'(out_idx[1]), 64'd3); chk("io_first_data", 64'(out_data[1]), 64'h53);
        @(negedge clk); chk("io_second_idx", 64'(out_idx[1]), 64'd0); chk("io_second_data", 64'(out_data[1]), 64'h50);
        @(negedge clk); chk("io_drained", 64'(busy[1]), 64'd0);
        tick();
        do_flush();

        // Order queue full
        out_ready = 1'b0;
        issue_valid = 1'b1; issue_idx = 3'd2;
        repeat (8) tick();
        issue_valid = 1'b0;
        @(negedge clk); chk("ord_full", 64'(issue_ready[1]), 64'd0);
        in_valid = 5'b00100; in_data[2] = 'h77;
        tick();
        in_valid = '0;
        @(negedge clk); chk("ord_head_valid", 64'(out_valid[1]), 64'd1);
        issue_valid = 1'b1; out_ready = 1'b1;
        tick();
        issue_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk); chk("ord_after_pop", 64'(issue_ready[1]), 64'd1); chk("ord_busy", 64'(busy[1]), 64'd1);
        issue_valid = 1'b1;
        tick();
        issue_valid = 1'b0;
        @(negedge clk); chk("ord_refull", 64'(issue_ready[1]), 64'd0);
        do_flush();

        // Flush mid-operation
        out_ready = 1'b1;
        in_valid = 5'b01000; in_data[3] = 'h33;
        tick();
        in_valid = '0;
        tick();
        out_ready = 1'b0;
        in_valid = 5'b01011; in_data[0] = 'h30; in_data[1] = 'h31; in_data[3] = 'h34;
        issue_valid = 1'b1; issue_idx = 3'd1;
        tick();
        in_valid = '0;
        tick(); tick(); tick();
        issue_valid = 1'b0;
        @(negedge clk);
        chk("pre_flush_idx", 64'(out_idx[0]), 64'd0);
        chk("pre_flush_busy_io", 64'(busy[1]), 64'd1);
        do_flush();
        @(negedge clk);
        chk("flush_busy_rr", 64'(busy[0]), 64'd0);
        chk("flush_busy_io", 64'(busy[1]), 64'd0);
        chk("flush_valid_rr", 64'(out_valid[0]), 64'd0);
        in_valid = 5'b10100; in_data[2] = 'h22; in_data[4] = 'h44;
        tick();
        in_valid = '0;
        @(negedge clk);
        chk("flush_rr_idx", 64'(out_idx[0]), 64'd2);
        chk("flush_rr_data", 64'(out_data[0]), 64'h22);
        do_flush();

        // Randomized traffic, checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            out_ready   = ($urandom_range(0, 3) != 0);
            in_valid    = N'($urandom);
            for (int i = 0; i < N; i++) in_data[i] = {6'($urandom), 32'($urandom)};
            issue_valid = ($urandom_range(0, 1) == 1);
            issue_idx   = IW'($urandom_range(0, N - 1));
            flush       = ($urandom_range(0, 99) == 0);
            tick();
        end
        flush = 1'b0; in_valid = '0; issue_valid = 1'b0; out_ready = 1'b1;
        repeat (20) tick();
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
